// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM state encoding
// and the WIDTH+1 bit add helper used by all arithmetic ops.
package alu_seq_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_INC = 4'b0010;
   localparam logic [3:0] OP_DEC = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Widest operand the add helper supports.
   localparam int MAX_W = 64;

   typedef struct packed {
      logic [MAX_W-1:0] sum;
      logic             carry;
      logic             ovf;
   } add_res_t;

   // Add two zero-extended operands plus carry-in. msb_mask is one-hot at the
   // operand sign bit (bit WIDTH-1); carry is the bit just above it, and ovf
   // flags equal operand signs with a differing result sign.
   function automatic add_res_t add_ovf(input logic [MAX_W-1:0] a,
                                        input logic [MAX_W-1:0] b,
                                        input logic             cin,
                                        input logic [MAX_W-1:0] msb_mask);
      logic [MAX_W:0] s;
      logic           sa, sb, ss;
      add_res_t       r;
      s       = {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
      sa      = |(a & msb_mask);
      sb      = |(b & msb_mask);
      ss      = |(s[MAX_W-1:0] & msb_mask);
      r.sum   = s[MAX_W-1:0];
      r.carry = |(s & {msb_mask, 1'b0});
      r.ovf   = (sa == sb) && (ss != sa);
      return r;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one step per cycle. load captures the
// operands and arms the counter at WIDTH-1; each step adds the multiplicand
// into the upper half when the current multiplier bit is set, then shifts
// right. prod is the value after the current step, so the owner registers it
// on the step where last=1.
module alu_mul_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 last
);

   logic [2*WIDTH-1:0] p;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     upper;

   // Next partial product: conditional add into the upper half, then shift.
   always_comb begin
      upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
      prod  = {upper, p[WIDTH-1:1]};
      last  = (cnt == '0);
   end

   // Iteration counter, WIDTH-1 down to 0.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(WIDTH - 1);
      else if (step)
         cnt <= cnt - 1'b1;
   end

   // Accumulator / multiplier shift register and multiplicand.
   always_ff @(posedge clk) begin
      if (load) begin
         p     <= {{WIDTH{1'b0}}, b};
         mcand <= a;
      end else if (step) begin
         p     <= prod;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with start/done handshake. Single-cycle ops register their
// result at the accept edge; MUL (only when ALU_SEQ_MUL_EN is defined) runs a
// WIDTH-cycle shift-add sequence. Without ALU_SEQ_MUL_EN, Op 1000 behaves as a
// reserved op and busy is tied low.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             c_in,
   output logic [WIDTH-1:0] R,
   output logic [WIDTH-1:0] RH,
   output logic             zero,
   output logic             carry,
   output logic             sign,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam logic [MAX_W-1:0] MSB_M = MAX_W'(1) << (WIDTH - 1);

   state_t             state, state_n;
   logic               accept, is_mul;
   logic [2*WIDTH-1:0] mul_prod;
   logic               mul_last;
   logic [WIDTH-1:0]   b_op, res;
   logic               cin_op, arith, c_n, v_n;
   add_res_t           ar;
   logic               unused_sum_hi;

   assign accept = start && (state == ST_IDLE);

`ifdef ALU_SEQ_MUL_EN
   assign is_mul = (Op == OP_MUL);
   assign busy   = (state == ST_MUL);

   alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk   (clk),
      .reset (reset),
      .load  (accept && is_mul),
      .step  (state == ST_MUL),
      .a     (A),
      .b     (B),
      .prod  (mul_prod),
      .last  (mul_last)
   );
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
   assign is_mul       = 1'b0;
   assign busy         = 1'b0;
   assign mul_prod     = '0;
   assign mul_last     = 1'b0;
`endif

   // Single-cycle datapath: pick the adder operands or a logic result.
   // Reserved codes (and MUL when it is not built) leave everything at 0.
   always_comb begin
      b_op   = B;
      cin_op = c_in;
      arith  = 1'b0;
      res    = '0;
      case (Op)
         OP_ADD: arith = 1'b1;
         OP_SUB: begin b_op = ~B; cin_op = 1'b1; arith = 1'b1; end
         OP_INC: begin b_op = '0; cin_op = 1'b1; arith = 1'b1; end
         OP_DEC: begin b_op = '1; cin_op = 1'b0; arith = 1'b1; end
         OP_AND: res = A & B;
         OP_OR:  res = A | B;
         OP_XOR: res = A ^ B;
         OP_NOT: res = ~A;
         default: res = '0;
      endcase
      ar  = add_ovf(MAX_W'(A), MAX_W'(b_op), cin_op, MSB_M);
      c_n = arith && ar.carry;
      v_n = arith && ar.ovf;
      if (arith)
         res = ar.sum[WIDTH-1:0];
   end

   assign unused_sum_hi = ^(ar.sum >> WIDTH);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   // FSM next state: enter MUL on an accepted multiply, leave on the last step.
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept && is_mul) state_n = ST_MUL;
         ST_MUL:  if (mul_last)         state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Result/flag registers and done pulse; values hold until the next done.
   always_ff @(posedge clk) begin
      if (reset) begin
         R     <= '0;
         RH    <= '0;
         zero  <= 1'b0;
         carry <= 1'b0;
         sign  <= 1'b0;
         ovf   <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept && !is_mul) begin
            R     <= res;
            RH    <= '0;
            zero  <= (res == '0);
            carry <= c_n;
            sign  <= res[WIDTH-1];
            ovf   <= v_n;
            done  <= 1'b1;
         end else if ((state == ST_MUL) && mul_last) begin
            R     <= mul_prod[WIDTH-1:0];
            RH    <= mul_prod[2*WIDTH-1:WIDTH];
            zero  <= (mul_prod == '0);
            carry <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
            sign  <= mul_prod[WIDTH-1];
            ovf   <= 1'b0;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): each issued op pushes its expected
// result; a negedge monitor pops and compares whenever done is high.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset, start, c_in;
   logic [3:0]   Op;
   logic [W-1:0] A, B, R, RH;
   logic         zero, carry, sign, ovf, busy, done;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .Op(Op), .A(A), .B(B),
      .c_in(c_in), .R(R), .RH(RH), .zero(zero), .carry(carry), .sign(sign),
      .ovf(ovf), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // {R, RH, zero, carry, sign, ovf, busy}
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] rh;
      logic       z, c, s, v, b;
   } obs_t;

   typedef struct {
      string name;
      obs_t  e;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   n_vec = 0;
   int   n_bad = 0;
   logic busy_seen = 1'b0;

   function automatic obs_t mk(input logic [7:0] r, input logic [7:0] rh,
                               input logic z, input logic c, input logic s,
                               input logic v);
      return {r, rh, z, c, s, v, 1'b0};
   endfunction

   function automatic obs_t cur();
      return {R, RH, zero, carry, sign, ovf, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input string name, input obs_t e, input bit push);
      Op = op; A = a; B = b; c_in = cin; start = 1'b1;
      if (push) begin
         exp_t x;
         x.name = name;
         x.e    = e;
         sb.push_back(x);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Monitor: every done pops one expectation; busy must be low while done.
   always @(negedge clk) begin
      if (busy === 1'b1)
         busy_seen = 1'b1;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 with R=%h RH=%h, required no pending op", R, RH);
         end else begin
            mon_x = sb.pop_front();
            check(mon_x.name, 32'(cur()), 32'(mon_x.e));
         end
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0; Op = 4'h0; A = '0; B = '0; c_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state", 32'({cur(), done}), 32'd0);
      @(posedge clk); #1;

      // Arithmetic and logic, back to back
      issue(OP_ADD, 8'hFF, 8'h01, 1'b0, "add_ff_01", mk(8'h00, 8'h00, 1, 1, 0, 0), 1);
      issue(OP_SUB, 8'h05, 8'h07, 1'b0, "sub_05_07", mk(8'hFE, 8'h00, 0, 0, 1, 0), 1);
      issue(OP_ADD, 8'h7F, 8'h01, 1'b0, "add_ovf",   mk(8'h80, 8'h00, 0, 0, 1, 1), 1);
      issue(OP_ADD, 8'h01, 8'h01, 1'b1, "add_cin",   mk(8'h03, 8'h00, 0, 0, 0, 0), 1);
      issue(OP_SUB, 8'h07, 8'h05, 1'b0, "sub_07_05", mk(8'h02, 8'h00, 0, 1, 0, 0), 1);
      issue(OP_SUB, 8'h80, 8'h01, 1'b0, "sub_ovf",   mk(8'h7F, 8'h00, 0, 1, 0, 1), 1);
      issue(OP_INC, 8'hFF, 8'h00, 1'b0, "inc_ff",    mk(8'h00, 8'h00, 1, 1, 0, 0), 1);
      issue(OP_INC, 8'h7F, 8'h00, 1'b0, "inc_7f",    mk(8'h80, 8'h00, 0, 0, 1, 1), 1);
      issue(OP_DEC, 8'h00, 8'h00, 1'b0, "dec_00",    mk(8'hFF, 8'h00, 0, 0, 1, 0), 1);
      issue(OP_DEC, 8'h80, 8'h00, 1'b0, "dec_80",    mk(8'h7F, 8'h00, 0, 1, 0, 1), 1);
      issue(OP_AND, 8'hF0, 8'h3C, 1'b0, "and",       mk(8'h30, 8'h00, 0, 0, 0, 0), 1);
      issue(OP_OR,  8'hF0, 8'h0C, 1'b0, "or",        mk(8'hFC, 8'h00, 0, 0, 1, 0), 1);
      issue(OP_XOR, 8'hAA, 8'hFF, 1'b0, "xor",       mk(8'h55, 8'h00, 0, 0, 0, 0), 1);
      issue(OP_NOT, 8'h0F, 8'hAA, 1'b1, "not",       mk(8'hF0, 8'h00, 0, 0, 1, 0), 1);
      issue(4'b1001, 8'h03, 8'h03, 1'b1, "rsvd_1001", mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
      issue(OP_ADD, 8'h03, 8'h04, 1'b0, "add_03_04", mk(8'h07, 8'h00, 0, 0, 0, 0), 1);
      issue(4'b1111, 8'hFF, 8'hFF, 1'b1, "rsvd_1111", mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
      issue(OP_ADD, 8'h10, 8'h20, 1'b0, "add_10_20", mk(8'h30, 8'h00, 0, 0, 0, 0), 1);

      // Reset and start in the same cycle: reset wins, outputs clear, no done
      reset = 1'b1;
      issue(OP_ADD, 8'h01, 8'h01, 1'b0, "", mk(8'h00, 8'h00, 0, 0, 0, 0), 0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_wins", 32'({cur(), done}), 32'd0);
      @(posedge clk); #1;
      issue(OP_ADD, 8'h03, 8'h04, 1'b0, "add_after_rst", mk(8'h07, 8'h00, 0, 0, 0, 0), 1);

`ifdef ALU_SEQ_MUL_EN
      // MUL FF*FF with an ignored start mid-run and a start in the done cycle
      issue(OP_XOR, 8'hAA, 8'hFF, 1'b0, "xor_pre_mul", mk(8'h55, 8'h00, 0, 0, 0, 0), 1);
      issue(OP_MUL, 8'hFF, 8'hFF, 1'b0, "mul_ff_ff",   mk(8'h01, 8'hFE, 0, 1, 0, 0), 1);
      for (int c = 1; c <= 8; c++) begin
         if (c == 3) begin
            Op = OP_ADD; A = 8'h05; B = 8'h05; c_in = 1'b0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         check("mul_busy_hold", 32'({busy, done, R, RH, zero, carry, sign, ovf}),
               32'({1'b1, 1'b0, 8'h55, 8'h00, 4'b0000}));
         @(posedge clk); #1;
      end
      start = 1'b0;
      Op = OP_ADD; A = 8'h01; B = 8'h01; c_in = 1'b0; start = 1'b1;
      begin
         exp_t x;
         x.name = "add_in_done_cycle";
         x.e    = mk(8'h02, 8'h00, 0, 0, 0, 0);
         sb.push_back(x);
      end
      @(negedge clk);
      check("mul_done_busy", 32'({busy, done}), 32'({1'b0, 1'b1}));
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;

      // MUL by zero, then XOR accepted in its done cycle
      issue(OP_MUL, 8'h0C, 8'h00, 1'b0, "mul_0c_00", mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
      repeat (8) @(posedge clk);
      #1;
      issue(OP_XOR, 8'hAA, 8'hFF, 1'b0, "xor_post_mul", mk(8'h55, 8'h00, 0, 0, 0, 0), 1);
      issue(OP_MUL, 8'h03, 8'h03, 1'b0, "mul_03_03", mk(8'h09, 8'h00, 0, 0, 0, 0), 1);
      repeat (9) @(posedge clk);
      #1;

      // Reset in cycle 4 of a MUL aborts it
      issue(OP_MUL, 8'h12, 8'h34, 1'b0, "", mk(8'h00, 8'h00, 0, 0, 0, 0), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("mul_abort", 32'({cur(), done}), 32'd0);
      @(posedge clk); #1;
      issue(OP_ADD, 8'h03, 8'h04, 1'b0, "add_after_abort", mk(8'h07, 8'h00, 0, 0, 0, 0), 1);
`else
      // Multiplier not built: Op 1000 is reserved with latency 1
      issue(OP_MUL, 8'h03, 8'h03, 1'b0, "mul_as_rsvd", mk(8'h00, 8'h00, 1, 0, 0, 0), 1);
`endif

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 40 && sb.size() != 0; i++)
         @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      repeat (12) @(posedge clk);
`ifndef ALU_SEQ_MUL_EN
      check("busy_never", 32'(busy_seen), 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor of the 4-bit combinational ALU: WIDTH-bit operands, registered result and flags, and a start/done handshake.
- Single-cycle ops: add/sub/inc/dec and logic. Multi-cycle op: unsigned shift-add multiply producing a 2*WIDTH-bit product.
- Sits between the register file and the datapath controller; the controller issues start and waits for done.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  op request; accepted only when busy=0.
- Op  in  4  operation code (encoding below).
- A  in  WIDTH  operand A, captured on accept.
- B  in  WIDTH  operand B, captured on accept.
- c_in  in  1  carry-in for ADD, captured on accept.
- R  out  WIDTH  result; low half of the product for MUL.
- RH  out  WIDTH  high half of the product; 0 for all other ops.
- zero  out  1  result == 0 (full 2*WIDTH product for MUL).
- carry  out  1  carry-out.
- sign  out  1  R[WIDTH-1].
- ovf  out  1  two's-complement overflow.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse when R/RH/flags are valid and updated.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset: R, RH, zero, carry, sign, ovf, busy, done = 0; state = IDLE. Reset wins over start in the same cycle.
- Reset mid-MUL aborts the multiply. No done is produced, and outputs read 0 on the next edge.
- Accept: at a rising edge with start=1 and busy=0 (state IDLE), A, B, c_in and Op are captured.
- start while busy=1 is ignored, with no queuing and no effect.
- Op encoding:
  - 0000 ADD: A+B+c_in.
  - 0001 SUB: A+~B+1.
  - 0010 INC: A+1.
  - 0011 DEC: A+~0.
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOT A.
  - 1000 MUL: unsigned A*B.
  - 1001-1111 reserved.
- Arithmetic widths: all adds are WIDTH+1 bits; carry = bit WIDTH. For SUB, carry=1 means no borrow.
- Overflow: ovf = signed overflow of the WIDTH-bit add (operand signs equal, result sign differs).
- Logic ops: carry=0, ovf=0.
- Reserved ops: R=0, RH=0, zero=1, all other flags 0, latency 1.
- Single-cycle ops: results and flags register at the accept edge. done=1 for the following cycle. busy stays 0.
- MUL state machine: IDLE -> MUL on accept.
  - MUL lasts WIDTH cycles, one shift-add step per cycle; the counter runs WIDTH-1 down to 0; busy=1 throughout.
  - At the edge where the counter is 0: register {RH,R}, set flags, pulse done, return to IDLE.
  - done is high during the cycle WIDTH+1 after accept. busy is low in that cycle, and a new start is accepted in it.
- MUL flags: carry = (RH != 0); zero = ({RH,R} == 0); sign = R[WIDTH-1]; ovf = 0.
- Hold behaviour: R, RH and flags hold their last values until the next done. Intermediate multiply state is internal and never visible on R/RH.
- done is never asserted for two consecutive cycles by the same op.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL, the MUL state and busy behave as above.
- Undefined: no multiplier logic; Op 1000 is treated as reserved (R=0, RH=0, zero=1, latency 1); busy is tied to 0. The port list is unchanged.

Decomposition:
- Shared package alu_seq_pkg:
  - Op code localparams OP_ADD..OP_NOT, OP_MUL.
  - State encoding ST_IDLE, ST_MUL.
  - Function for the WIDTH+1 add with overflow.
- One sub-module, alu_mul_seq (only when ALU_SEQ_MUL_EN):
  - Shift-add multiplier with load/step/last handshake.
  - Holds the accumulator, multiplier shift register and counter.
- The top level keeps the single-cycle datapath, flag logic and state machine.

Test Plan (WIDTH=8):
- ADD A=FF B=01 c_in=0 -> one cycle later: done=1, R=00, zero=1, carry=1, sign=0, ovf=0, busy=0.
- SUB A=05 B=07 -> R=FE, carry=0, sign=1, ovf=0. ADD A=7F B=01 c_in=0 -> R=80, ovf=1, sign=1.
- MUL A=FF B=FF at cycle 0 -> busy=1 cycles 1-8; done=1 cycle 9; RH=FE, R=01, carry=1, zero=0.
  - start with ADD at cycle 3 is ignored; R/RH/flags unchanged until cycle 9.
  - start with ADD 01+01 (c_in=0) at cycle 9 (the done cycle) is accepted -> done=1 cycle 10, R=02, RH=00, carry=0.
- MUL A=0C B=00 -> done cycle 9, RH=00, R=00, zero=1, carry=0. Then XOR A=AA B=FF -> R=55, carry=0, ovf=0.
- reset=1 at cycle 4 of a MUL -> next edge: all outputs 0, no done; ADD 03+04 afterwards -> R=07 after 1 cycle.
- ALU_SEQ_MUL_EN undefined: Op=1000 A=03 B=03 -> done after 1 cycle, R=00, RH=00, zero=1, busy never 1.
